// File: rtl/tmax_acs_pipe.sv
// tmax_acs_pipe: two-stage multi-lane max/max* add-compare-select with joint metric normalisation.
// Defining TMAX_MAXSTAR_CORR_EN adds the max* correction term in stage 2.
module tmax_acs_pipe #(
  parameter int W = 16,
  parameter int LANES = 8,
  parameter int NORM_THR = 16384
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*W-1:0]       old0_i,
  input  logic [LANES*W-1:0]       old1_i,
  input  logic [LANES*W-1:0]       m0_i,
  input  logic [LANES*W-1:0]       m1_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*(W+1)-1:0]   alpha_o,
  output logic [LANES-1:0]         dec_o,
  output logic                     norm_o
);
  localparam logic [W:0]   thr     = (W+1)'(NORM_THR);
  localparam logic [W+1:0] floor_v = {2'b11, {W{1'b0}}};
  localparam logic [W+1:0] ceil_v  = {2'b00, {W{1'b1}}};
  logic s1_valid, s2_valid, s1_adv, s2_adv, norm_c, norm_r;
  logic [LANES-1:0][W:0] sel_c, s1_sel, cor, nrm, alpha_r;
  logic [LANES-1:0] dec_c, s1_dec, over, dec_r;
`ifdef TMAX_MAXSTAR_CORR_EN
  logic [LANES-1:0][1:0] corr_c, s1_corr;
`endif
  assign s2_adv    = !s2_valid | out_ready;
  assign s1_adv    = !s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign alpha_o   = alpha_r;
  assign dec_o     = dec_r;
  assign norm_o    = norm_r;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [W:0] d0, d1;
    logic [W+1:0] sub;
    assign d0 = {old0_i[k*W+W-1], old0_i[k*W +: W]} + {m0_i[k*W+W-1], m0_i[k*W +: W]};
    assign d1 = {old1_i[k*W+W-1], old1_i[k*W +: W]} + {m1_i[k*W+W-1], m1_i[k*W +: W]};
    assign dec_c[k] = $signed(d0) > $signed(d1);
    assign sel_c[k] = dec_c[k] ? d0 : d1;
`ifdef TMAX_MAXSTAR_CORR_EN
    logic [W+1:0] df, ad, cs;
    assign df = {d0[W], d0} - {d1[W], d1};
    assign ad = dec_c[k] ? df : -df;
    assign corr_c[k] = ad < (W+2)'(2) ? 2'd3 : ad < (W+2)'(4) ? 2'd2 : ad < (W+2)'(8) ? 2'd1 : 2'd0;
    assign cs = {s1_sel[k][W], s1_sel[k]} + {{W{1'b0}}, s1_corr[k]};
    assign cor[k] = $signed(cs) > $signed(ceil_v) ? ceil_v[W:0] : cs[W:0];
`else
    assign cor[k] = s1_sel[k];
`endif
    assign over[k] = $signed(cor[k]) >= $signed(thr);
    // Subtraction is done one bit wider so the floor clamp can see underflow.
    assign sub = {cor[k][W], cor[k]} - {thr[W], thr};
    assign nrm[k] = norm_c ? ($signed(sub) < $signed(floor_v) ? floor_v[W:0] : sub[W:0]) : cor[k];
  end
  assign norm_c = |over;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_dec   <= '0;
`ifdef TMAX_MAXSTAR_CORR_EN
      s1_corr  <= '0;
`endif
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sel  <= sel_c;
        s1_dec  <= dec_c;
`ifdef TMAX_MAXSTAR_CORR_EN
        s1_corr <= corr_c;
`endif
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_valid <= 1'b0;
      alpha_r  <= '0;
      dec_r    <= '0;
      norm_r   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        alpha_r <= nrm;
        dec_r   <= s1_dec;
        norm_r  <= norm_c;
      end
    end
endmodule

// File: tb/tb_tmax_acs_pipe.sv
// tb_tmax_acs_pipe: directed self-checking bench for tmax_acs_pipe (default parameters).
module tb_tmax_acs_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1, norm_o;
  logic [127:0] old0_i = '0, old1_i = '0, m0_i = '0, m1_i = '0;
  logic [135:0] alpha_o;
  logic [7:0] dec_o;
  int checks = 0, passes = 0;
`ifdef TMAX_MAXSTAR_CORR_EN
  localparam bit ce = 1'b1;
`else
  localparam bit ce = 1'b0;
`endif
  tmax_acs_pipe dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .old0_i(old0_i), .old1_i(old1_i), .m0_i(m0_i), .m1_i(m1_i), .out_valid(out_valid),
    .out_ready(out_ready), .alpha_o(alpha_o), .dec_o(dec_o), .norm_o(norm_o));
  always #5 clk = ~clk;

  task automatic set_in(input logic [15:0] a0, b0, c0, e0, a1, b1, c1, e1);
    old0_i = '0; m0_i = '0; old1_i = '0; m1_i = '0;
    old0_i[15:0] = a0; m0_i[15:0] = b0; old1_i[15:0] = c0; m1_i[15:0] = e0;
    old0_i[31:16] = a1; m0_i[31:16] = b1; old1_i[31:16] = c1; m1_i[31:16] = e1;
  endtask

  task automatic send_one();
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (out_valid !== 1'b0) $display("FAIL early_valid: got %b want 0", out_valid); else passes++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL latency_valid: got %b want 1", out_valid); else passes++;
  endtask

  task automatic test_reset();
    rst_n = 0; #12;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passes++;
    checks++; if (alpha_o !== '0 || dec_o !== '0 || norm_o !== 1'b0)
      $display("FAIL rst_outputs: alpha=%h dec=%h norm=%b want zeros", alpha_o, dec_o, norm_o); else passes++;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passes++;
  endtask

  task automatic test_basic();
    set_in(16'h0010, 16'h0005, 16'h0008, 16'h000A, 0, 0, 0, 0);
    send_one();
    checks++; if (alpha_o[16:0] !== (ce ? 17'h00017 : 17'h00015) || dec_o[0] !== 1'b1 || norm_o !== 1'b0)
      $display("FAIL basic_pos: alpha=%h dec=%b norm=%b want %h 1 0", alpha_o[16:0], dec_o[0], norm_o, ce ? 17'h00017 : 17'h00015); else passes++;
    checks++; if (alpha_o[33:17] !== (ce ? 17'h00003 : 17'h00000) || dec_o[1] !== 1'b0)
      $display("FAIL basic_zero_lane: alpha=%h dec=%b", alpha_o[33:17], dec_o[1]); else passes++;
    set_in(16'hFFF0, 16'hFFFF, 16'h0001, 16'hFFF0, 0, 0, 0, 0);
    send_one();
    checks++; if (alpha_o[16:0] !== (ce ? 17'h1FFF3 : 17'h1FFF1) || dec_o[0] !== 1'b0)
      $display("FAIL basic_neg: alpha=%h dec=%b want %h 0", alpha_o[16:0], dec_o[0], ce ? 17'h1FFF3 : 17'h1FFF1); else passes++;
    set_in(16'h0004, 16'h0004, 16'h0004, 16'h0004, 0, 0, 0, 0);
    send_one();
    checks++; if (alpha_o[16:0] !== (ce ? 17'h0000B : 17'h00008) || dec_o[0] !== 1'b0)
      $display("FAIL tie: alpha=%h dec=%b want %h 0", alpha_o[16:0], dec_o[0], ce ? 17'h0000B : 17'h00008); else passes++;
  endtask

  task automatic test_norm();
    set_in(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    send_one();
    checks++; if (norm_o !== 1'b1 || alpha_o[16:0] !== 17'h0BFFE || dec_o[0] !== 1'b1)
      $display("FAIL norm_sub: norm=%b alpha=%h dec=%b want 1 0bffe 1", norm_o, alpha_o[16:0], dec_o[0]); else passes++;
    checks++; if (alpha_o[33:17] !== 17'h10000 || dec_o[1] !== 1'b0)
      $display("FAIL norm_floor: alpha=%h dec=%b want 10000 0", alpha_o[33:17], dec_o[1]); else passes++;
    set_in(16'h2000, 16'h2000, 0, 0, 0, 0, 0, 0);
    send_one();
    checks++; if (norm_o !== 1'b1 || alpha_o[16:0] !== 17'h00000)
      $display("FAIL norm_at_thr: norm=%b alpha=%h want 1 00000", norm_o, alpha_o[16:0]); else passes++;
    set_in(16'h2000, 16'h1FFF, 0, 0, 0, 0, 0, 0);
    send_one();
    checks++; if (norm_o !== 1'b0 || alpha_o[16:0] !== 17'h03FFF)
      $display("FAIL norm_below_thr: norm=%b alpha=%h want 0 03fff", norm_o, alpha_o[16:0]); else passes++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = i < 4;
      set_in(16'((i + 1) * 16), 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (i < 4) begin
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); else passes++;
      end
      @(posedge clk); #1;
      if (i >= 1 && i <= 4) begin
        checks++; if (out_valid !== 1'b1 || alpha_o[16:0] !== 17'(i * 16))
          $display("FAIL b2b_out[%0d]: valid=%b alpha=%h want 1 %h", i, out_valid, alpha_o[16:0], 17'(i * 16)); else passes++;
      end
    end
    in_valid = 0;
  endtask

  task automatic test_backpressure();
    int sent = 0, recv = 0;
    bit saw_stall = 0, stalled = 0;
    logic [135:0] held = '0;
    for (int c = 0; c < 40 && recv < 5; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid = sent < 5;
      set_in(16'((sent + 1) * 16 + 3), 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (stalled) begin
        checks++; if (alpha_o !== held) $display("FAIL bp_stable: alpha=%h want %h", alpha_o, held); else passes++;
      end
      if (in_valid && !in_ready) saw_stall = 1;
      stalled = out_valid && !out_ready;
      held = alpha_o;
      if (out_valid && out_ready) begin
        checks++; if (alpha_o[16:0] !== 17'((recv + 1) * 16 + 3))
          $display("FAIL bp_order[%0d]: alpha=%h want %h", recv, alpha_o[16:0], 17'((recv + 1) * 16 + 3)); else passes++;
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    checks++; if (recv !== 5) $display("FAIL bp_count: got %0d want 5", recv); else passes++;
    checks++; if (!saw_stall) $display("FAIL bp_in_ready_drop: got %b want 1", saw_stall); else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    set_in(16'h0100, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1;
    @(posedge clk); #1;
    set_in(16'h0200, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) $display("FAIL ar_inflight: got %b want 1", out_valid); else passes++;
    #1 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || alpha_o !== '0 || dec_o !== '0)
      $display("FAIL ar_clear: valid=%b alpha=%h dec=%h want zeros", out_valid, alpha_o, dec_o); else passes++;
    @(negedge clk); rst_n = 1; out_ready = 1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL ar_in_ready: got %b want 1", in_ready); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b0) $display("FAIL ar_stale[%0d]: got %b want 0", i, out_valid); else passes++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_norm();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tmax_acs_pipe.md
Name: tmax_acs_pipe

Overview:
- Parametrised, pipelined multi-lane add-compare-select (max / max*) unit for the turbo decoder's alpha/beta recursions.
- Each lane sign-extends and adds two (old metric + branch metric) pairs, selects the larger sum and emits a survivor decision bit.
- Metrics are normalised across all lanes together to prevent overflow.
- Sits between the branch-metric unit and the state-metric memory, with valid/ready handshakes on both sides.

Parameters:
- W, 16, width of each input metric (signed two's complement).
- LANES, 8, number of trellis states processed in parallel.
- NORM_THR, 16384, normalisation threshold and subtrahend (signed, W+1 bits).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input bundle valid.
- in_ready  output  1  block can accept the input bundle this cycle.
- old0_i  input  LANES*W  previous metric, path 0; lane k occupies bits [k*W +: W].
- old1_i  input  LANES*W  previous metric, path 1.
- m0_i  input  LANES*W  branch metric, path 0.
- m1_i  input  LANES*W  branch metric, path 1.
- out_valid  output  1  output bundle valid.
- out_ready  input  1  downstream accepts the output bundle.
- alpha_o  output  LANES*(W+1)  selected, normalised metric per lane; lane k occupies [k*(W+1) +: W+1].
- dec_o  output  LANES  survivor decision per lane; 1 = path 0 selected.
- norm_o  output  1  normalisation was applied to this bundle.

Behaviour:
- Arithmetic: every operand is sign-extended to W+1 bits. d0 = old0+m0 and d1 = old1+m1 are exact in W+1 bits, so they cannot overflow.
- Compare is signed. If d0 > d1 (strictly), select d0 and set dec = 1. Otherwise select d1 and set dec = 0, so ties select path 1.
- Stage 1 (registered): sums, signed compare result, select, decision. Registered on transfer (in_valid & in_ready).
- Stage 2 (registered): normalisation.
  - If any lane's selected metric >= NORM_THR, subtract NORM_THR from every lane and set norm_o = 1.
  - The subtraction saturates at -2^W. No lane may wrap.
  - Otherwise the metrics pass through unchanged and norm_o = 0.
- Latency: 2 cycles from input transfer to out_valid, with out_ready held high. Throughput is 1 bundle per cycle.
- Handshake:
  - Stage 2 advances when !s2_valid | out_ready.
  - Stage 1 advances when !s1_valid | stage-2 advance.
  - in_ready = stage-1 advance, which is combinational from out_ready.
  - out_valid = s2_valid.
  - alpha_o, dec_o and norm_o hold stable while out_valid & !out_ready.
  - No bundle is lost, duplicated or reordered.
- Reset (asynchronous, any time including mid-stream):
  - All pipeline valids clear, so out_valid = 0 and in-flight bundles are discarded.
  - alpha_o = 0, dec_o = 0, norm_o = 0.
  - in_ready = 1 in the first cycle after deassertion.
- in_valid while in_ready = 0: the input is not captured, and the source must hold it.

Optional Feature:
- Macro: TMAX_MAXSTAR_CORR_EN.
- Defined:
  - Stage 2 first adds the max* correction, a function of |d0-d1| carried in a stage-1 register: 3 if < 2, 2 if < 4, 1 if < 8, else 0.
  - The addition saturates at 2^W-1.
  - The corrected value then feeds the normalisation check and subtraction.
  - dec_o is unaffected.
- Undefined: pure max selection, no correction logic or extra registers. Latency is 2 in both builds.

Test Plan:
- Lane 0: old0=0x0010, m0=0x0005, old1=0x0008, m1=0x000A, out_ready=1 -> after 2 cycles alpha=17'h00015, dec=1, norm_o=0. With TMAX_MAXSTAR_CORR_EN (|d|=3) -> 17'h00017.
- Lane 0: old0=0xFFF0, m0=0xFFFF, old1=0x0001, m1=0xFFF0 -> d0=-17, d1=-15 -> alpha=17'h1FFF1, dec=0.
- Tie: all four operands = 0x0004 -> alpha=17'h00008, dec=0.
- Normalisation and floor:
  - Stimulus: lane 0 old0=m0=0x7FFF, old1=m1=0x8000 (max d0=65534); lane 1 all operands 0x8000 (-65536).
  - Response: norm_o=1, lane 0 alpha=17'h0BFFE (49150), lane 1 saturates at 17'h10000.
  - Without TMAX_MAXSTAR_CORR_EN.
- Backpressure:
  - Stimulus: stream 5 bundles, out_ready=0 for cycles 3-5.
  - Response: in_ready drops once both stages are full; alpha_o is stable while stalled; all 5 bundles emerge in order with none dropped or duplicated.
- Reset: assert rst_n=0 with 2 bundles in flight -> out_valid=0 and alpha_o=0 immediately; after release, in_ready=1 and no stale bundle appears.
